imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: receives a program as a byte stream
//  (valid/ready), packs bytes big-endian into 32-bit MIPS instruction words and writes them
//  to consecutive word addresses of instruction memory, which the single-cycle core then reads.
//  Holds the core in reset while loading; releases it when the programmed word count is written.
// PARAMETERS
//  ADDR_W    6    log2 of instruction-memory depth in words (64 words)
//  BASE_ADDR 0    byte address written for word 0 (word aligned)
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  reset       in   1        synchronous, active-high reset
//  start       in   1        1-cycle request to begin a load; sampled in IDLE and DONE only
//  word_count  in   ADDR_W+1 number of words to load, sampled with start; range 0..2**ADDR_W
//  byte_in     in   8        stream data byte
//  byte_valid  in   1        byte_in valid
//  byte_ready  out  1        loader accepts byte this cycle (transfer = valid & ready)
//  imem_we     out  1        instruction-memory write enable, 1-cycle pulse per word
//  imem_addr   out  32       byte address of write = BASE_ADDR + 4*index
//  imem_wd     out  32       instruction word to write
//  cpu_reset   out  1        reset to core; high in IDLE/RECV/WRITE, low only in DONE
//  busy        out  1        high in RECV and WRITE
//  done        out  1        high in DONE
//  checksum    out  32       XOR of all words written in current/last load
// BEHAVIOUR
//  Reset (synchronous, active-high): state=IDLE, index=0, byte_cnt=0, shift reg=0, checksum=0;
//   all outputs 0 except cpu_reset=1. Reset mid-load aborts; no further imem_we.
//  Clock and reset use only clk and reset; no other clocking or async reset.
//  States: IDLE, RECV, WRITE, DONE.
//   IDLE : start & word_count==0 -> DONE; start & word_count!=0 -> RECV (latch count,
//          index=0, byte_cnt=0, checksum=0). Otherwise stay.
//   RECV : byte_ready=1. On transfer: shift={shift[23:0],byte_in}, byte_cnt++;
//          4th byte (byte_cnt==3) -> WRITE, byte_ready drops next cycle. First byte -> [31:24].
//   WRITE: byte_ready=0; imem_we=1 for exactly this cycle with imem_addr/imem_wd stable;
//          checksum^=word; index++. index==count-1 -> DONE else RECV (byte_cnt=0).
//   DONE : done=1, cpu_reset=0, outputs hold last values, imem_we=0. start restarts as in IDLE
//          (cpu_reset reasserts the cycle after start is accepted).
//  start while busy: ignored. byte_valid outside RECV: not accepted, no state change.
//  Latency: word write occurs the cycle after its 4th byte transfers; max throughput 4 bytes
//   per 5 cycles. Gaps in byte_valid stall RECV indefinitely without losing partial bytes.
//  word_count > 2**ADDR_W: clamp to 2**ADDR_W; index never wraps past depth-1.
//  imem_addr = BASE_ADDR + {index,2'b00}, 32-bit, upper bits zero-extended.
// STRUCTURE
//  Shared package/header: state encodings (IDLE/RECV/WRITE/DONE), BYTES_PER_WORD=4.
//  Sub-module byte_packer: 8->32 shift register + 2-bit byte counter, outputs word and
//   word_full; loader FSM, index counter, checksum stay in imem_loader top.
// TESTING
//  1 reset, no start, 20 cycles -> cpu_reset=1, busy=0, done=0, imem_we never 1.
//  2 start, count=1, bytes 20 08 00 10 -> one imem_we, addr=0x0, wd=0x20080010 (addi $t0,
//    $zero,16), then done=1, cpu_reset=0, checksum=0x20080010.
//  3 count=3 words 0x20080010, 0x01084020, 0xAC080004 with byte_valid gaps of 0-3 cycles
//    -> writes at addr 0,4,8 in order, data exact, checksum=0x8D084034.
//  4 start asserted during RECV and byte_valid in IDLE/DONE -> ignored; no extra writes.
//  5 reset asserted after 2 bytes of word 1 -> IDLE next cycle, no imem_we; new load with
//    count=1 writes clean word at addr 0.
//  6 start with count=0 -> DONE next cycle, no writes; restart from DONE with count=2 works.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding and word geometry for the instruction-memory loader
package imem_loader_pkg;
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: big-endian 8->32 shift register; word_full flags the transfer completing a word
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);
    logic [1:0] byte_cnt;

    assign word_full = shift_en && byte_cnt == 2'(BYTES_PER_WORD - 1);

    // The counter wraps to 0 on the 4th byte, so no explicit clear is needed between words
    always_ff @(posedge clk) begin
        if (reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into instruction words, writes them to imem, holds the core in reset meanwhile
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    output logic            imem_we,
    output logic [31:0]     imem_addr,
    output logic [31:0]     imem_wd,
    output logic            cpu_reset,
    output logic            busy,
    output logic            done,
    output logic [31:0]     checksum
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(1) << ADDR_W;

    state_t            state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] index;
    logic [31:0]       word;
    logic              word_full;
    logic              accept;
    logic              last;

    assign accept  = start && (state == IDLE || state == DONE);
    assign last    = {1'b0, index} == count - 1'b1;
    assign imem_wd = word;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .shift_en  (byte_valid && byte_ready),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    // Outputs are set on the transition into each state so they are aligned with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            index      <= '0;
            checksum   <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        index     <= '0;
                        checksum  <= '0;
                        count     <= word_count > DEPTH ? DEPTH : word_count;
                        state     <= word_count == '0 ? DONE : RECV;
                        byte_ready <= word_count != '0;
                        busy      <= word_count != '0;
                        done      <= word_count == '0;
                        cpu_reset <= word_count != '0;
                    end
                end
                RECV: begin
                    if (word_full) begin
                        state      <= WRITE;
                        byte_ready <= 1'b0;
                        imem_we    <= 1'b1;
                        imem_addr  <= BASE_ADDR + 32'({index, 2'b00});
                    end
                end
                WRITE: begin
                    imem_we  <= 1'b0;
                    checksum <= checksum ^ word;
                    // Index stops at the last word so a full-depth load never wraps
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state      <= RECV;
                        index      <= index + 1'b1;
                        byte_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
